// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the multiplexed seven-segment display driver.
package hex_disp_pkg;

   typedef enum logic [1:0] {
      SCAN,
      SEL,
      CAP
   } scan_state_t;

   localparam logic [6:0]  SEG_BLANK  = 7'h7F;
   localparam int unsigned MAX_DIGITS = 8;

   // Bit offset of digit idx within the flattened segment bus.
   function automatic int unsigned digit_slice(input logic [2:0] idx);
      return 32'(idx) * 7;
   endfunction

endpackage

// File: rtl/hex_scan_ctrl_if.sv
// Digit write port between the game/score logic and the display scanner.
interface hex_scan_ctrl_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [2:0] wr_idx;
   logic [3:0] wr_val;
   logic       wr_blank;

   modport master (
      output wr_valid, wr_idx, wr_val, wr_blank,
      input  wr_ready
   );

   modport slave (
      input  wr_valid, wr_idx, wr_val, wr_blank,
      output wr_ready
   );
endinterface

// File: rtl/hex_scan_ctrl_hex7.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex7
   import hex_disp_pkg::*;
(
   input  logic [3:0] val,
   output logic [6:0] seg
);

   // Pure combinational glyph lookup.
   always_comb begin
      seg = SEG_BLANK;
      case (val)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Scans a digit buffer through one shared hex7 decoder into per-digit
// active-low segment registers. Optional blinking is enabled by defining
// HEX_SCAN_BLINK_EN (adds the blink_mask port and BLINK_FRAMES parameter).
module hex_scan_ctrl
   import hex_disp_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 6,
   parameter int unsigned SCAN_DIV     = 50000
`ifdef HEX_SCAN_BLINK_EN
   ,
   parameter int unsigned BLINK_FRAMES = 25
`endif
) (
   input  logic                    clk,
   input  logic                    rst_n,
   hex_scan_ctrl_if.slave          wr,
`ifdef HEX_SCAN_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
   output logic [7*NUM_DIGITS-1:0] hex_out,
   output logic                    frame_done,
   output logic                    wr_err
);

   localparam int unsigned      DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [2:0]       PTR_LAST = 3'(NUM_DIGITS - 1);

   scan_state_t           state, state_nx;
   logic [DIV_W-1:0]      div;
   logic [2:0]            ptr;
   logic [3:0]            dec_in;
   logic [6:0]            dec_seg;
   logic [3:0]            dig_val [MAX_DIGITS];
   logic [MAX_DIGITS-1:0] dig_blank;
   logic [6:0]            seg_reg [MAX_DIGITS];
   logic                  wr_fire;
   logic                  idx_ok;
   logic                  ptr_wrap;
   logic                  force_dark;

   assign wr_fire  = wr.wr_valid && wr.wr_ready;
   assign idx_ok   = {1'b0, wr.wr_idx} < 4'(NUM_DIGITS);
   assign ptr_wrap = (ptr == PTR_LAST);

   // Scan state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= SCAN;
      else        state <= state_nx;
   end

   // Next state, write ready and end-of-frame pulse.
   always_comb begin
      state_nx    = state;
      wr.wr_ready = 1'b0;
      frame_done  = 1'b0;
      case (state)
         SCAN: begin
            wr.wr_ready = 1'b1;
            if (div == DIV_LAST) state_nx = SEL;
         end
         SEL: state_nx = CAP;
         CAP: begin
            frame_done = ptr_wrap;
            state_nx   = SCAN;
         end
         default: state_nx = SCAN;
      endcase
   end

   // Dwell counter: runs only while scanning, clears on the way out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 div <= '0;
      else if (state != SCAN)     div <= '0;
      else if (div == DIV_LAST)   div <= '0;
      else                        div <= div + 1'b1;
   end

   // Digit pointer advance and registered decoder input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr    <= '0;
         dec_in <= '0;
      end else begin
         if (state == SEL) dec_in <= dig_val[ptr];
         if (state == CAP) ptr    <= ptr_wrap ? '0 : ptr + 3'd1;
      end
   end

   // Digit buffer writes; out-of-range indices are consumed and flagged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < MAX_DIGITS; i++) dig_val[i] <= '0;
         dig_blank <= '1;
         wr_err    <= 1'b0;
      end else if (wr_fire) begin
         if (idx_ok) begin
            dig_val[wr.wr_idx]   <= wr.wr_val;
            dig_blank[wr.wr_idx] <= wr.wr_blank;
         end else begin
            wr_err <= 1'b1;
         end
      end
   end

   hex7 u_hex7 (
      .val (dec_in),
      .seg (dec_seg)
   );

`ifdef HEX_SCAN_BLINK_EN
   localparam int unsigned   BF_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

   logic [BF_W-1:0]       fcnt;
   logic                  phase;
   logic [MAX_DIGITS-1:0] mask_ext;

   assign mask_ext   = MAX_DIGITS'(blink_mask);
   assign force_dark = phase && mask_ext[ptr];

   // Blink phase flips after every BLINK_FRAMES completed frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt  <= '0;
         phase <= 1'b0;
      end else if (frame_done) begin
         if (fcnt == BF_LAST) begin
            fcnt  <= '0;
            phase <= ~phase;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end
`else
   assign force_dark = 1'b0;
`endif

   // Capture the decoded glyph for the current digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < MAX_DIGITS; i++) seg_reg[i] <= SEG_BLANK;
      end else if (state == CAP) begin
         seg_reg[ptr] <= (dig_blank[ptr] || force_dark) ? SEG_BLANK : dec_seg;
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_out
      assign hex_out[digit_slice(3'(g)) +: 7] = seg_reg[g];
   end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl: cycle-position model, digit buffer
// model, and a scoreboard of expected captures compared after each CAP.
module tb_hex_scan_ctrl;

   localparam int ND    = 6;
   localparam int SD    = 4;
   localparam int BF    = 2;
   localparam int SLOT  = SD + 2;
   localparam int FRAME = ND * SLOT;

   localparam logic [6:0] SEG_REF [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef struct {
      int         idx;
      logic [6:0] seg;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [7*ND-1:0] hex_out;
   logic            frame_done;
   logic            wr_err;
`ifdef HEX_SCAN_BLINK_EN
   logic [ND-1:0]   blink_mask;
   logic [ND-1:0]   m_mask;
`endif

   int         n_pass  = 0;
   int         n_total = 0;
   int         cyc;
   logic [3:0] m_val   [ND];
   logic       m_blank [ND];
   exp_t       scb[$];
   exp_t       mon_e;
   int         mon_p;
   logic [6:0] mon_s;

   always #5 clk = ~clk;

   hex_scan_ctrl_if wr_if ();

   hex_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .SCAN_DIV     (SD)
`ifdef HEX_SCAN_BLINK_EN
      ,
      .BLINK_FRAMES (BF)
`endif
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr         (wr_if),
`ifdef HEX_SCAN_BLINK_EN
      .blink_mask (blink_mask),
`endif
      .hex_out    (hex_out),
      .frame_done (frame_done),
      .wr_err     (wr_err)
   );

   // Cycles since reset release; cycle k has slot phase k%SLOT (SD..: SEL, CAP).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Scoreboard: push the expected glyph during CAP, compare one cycle later.
   always @(negedge clk) begin
      if (!rst_n) begin
         scb.delete();
      end else begin
         if (scb.size() > 0) begin
            mon_e = scb.pop_front();
            n_total++;
            if (hex_out[mon_e.idx*7 +: 7] !== mon_e.seg)
               $display("FAIL scb_digit%0d: got %h want %h (cyc %0d)",
                        mon_e.idx, hex_out[mon_e.idx*7 +: 7], mon_e.seg, cyc);
            else
               n_pass++;
         end
         if (cyc % SLOT == SLOT - 1) begin
            mon_p = (cyc / SLOT) % ND;
            mon_s = m_blank[mon_p] ? 7'h7F : SEG_REF[m_val[mon_p]];
`ifdef HEX_SCAN_BLINK_EN
            if (m_mask[mon_p] && (((cyc / FRAME) / BF) % 2 == 1)) mon_s = 7'h7F;
`endif
            scb.push_back('{mon_p, mon_s});
         end
      end
   end

   function automatic logic [7*ND-1:0] full_exp();
      logic [7*ND-1:0] r;
      for (int d = 0; d < ND; d++) r[d*7 +: 7] = m_blank[d] ? 7'h7F : SEG_REF[m_val[d]];
      return r;
   endfunction

   task automatic clear_model();
      for (int d = 0; d < ND; d++) begin
         m_val[d]   = 4'h0;
         m_blank[d] = 1'b1;
      end
   endtask

   task automatic drive_write(input int i, input logic [3:0] v, input logic b);
      bit done = 1'b0;
      @(negedge clk);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_idx   = 3'(i);
      wr_if.wr_val   = v;
      wr_if.wr_blank = b;
      for (int n = 0; n < 2 * SLOT && !done; n++) begin
         done = (cyc % SLOT) < SD;
         @(posedge clk);
         if (done && i < ND) begin
            m_val[i]   = v;
            m_blank[i] = b;
         end
         @(negedge clk);
      end
      wr_if.wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      clear_model();
      rst_n = 1'b0;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_idx   = '0;
      wr_if.wr_val   = '0;
      wr_if.wr_blank = 1'b0;
`ifdef HEX_SCAN_BLINK_EN
      blink_mask = '0;
      m_mask     = '0;
`endif
      repeat (3) @(negedge clk);
      n_total++;
      if (hex_out !== {ND{7'h7F}}) $display("FAIL rst_hex: got %h want %h", hex_out, {ND{7'h7F}});
      else n_pass++;
      n_total++;
      if ({frame_done, wr_err, wr_if.wr_ready} !== 3'b001)
         $display("FAIL rst_flags: got %b want 001", {frame_done, wr_err, wr_if.wr_ready});
      else n_pass++;
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n_total++;
         if (frame_done !== (cyc % FRAME == FRAME - 1))
            $display("FAIL idle_frame_done: got %b want %b (cyc %0d)", frame_done, (cyc % FRAME == FRAME - 1), cyc);
         else n_pass++;
         n_total++;
         if (wr_if.wr_ready !== (cyc % SLOT < SD))
            $display("FAIL idle_ready: got %b want %b (cyc %0d)", wr_if.wr_ready, (cyc % SLOT < SD), cyc);
         else n_pass++;
         n_total++;
         if (hex_out !== {ND{7'h7F}}) $display("FAIL idle_hex: got %h want all 7F", hex_out);
         else n_pass++;
      end
   endtask

   task automatic test_write();
      drive_write(2, 4'hA, 1'b0);
      repeat (FRAME + SLOT) @(negedge clk);
      n_total++;
      if (hex_out[20:14] !== 7'b000_1000) $display("FAIL write_d2: got %h want 08", hex_out[20:14]);
      else n_pass++;
      n_total++;
      if (hex_out !== full_exp()) $display("FAIL write_all: got %h want %h", hex_out, full_exp());
      else n_pass++;
   endtask

   task automatic test_hold();
      for (int i = 0; i < SLOT && (cyc % SLOT) != SD; i++) @(negedge clk);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_idx   = 3'd4;
      wr_if.wr_val   = 4'h5;
      wr_if.wr_blank = 1'b0;
      n_total++;
      if (wr_if.wr_ready !== 1'b0) $display("FAIL hold_ready_sel: got %b want 0", wr_if.wr_ready);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (wr_if.wr_ready !== 1'b0) $display("FAIL hold_ready_cap: got %b want 0", wr_if.wr_ready);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (wr_if.wr_ready !== 1'b1) $display("FAIL hold_ready_scan: got %b want 1", wr_if.wr_ready);
      else n_pass++;
      @(posedge clk);
      m_val[4]   = 4'h5;
      m_blank[4] = 1'b0;
      @(negedge clk);
      wr_if.wr_valid = 1'b0;
      repeat (FRAME + SLOT) @(negedge clk);
      n_total++;
      if (hex_out !== full_exp()) $display("FAIL hold_all: got %h want %h", hex_out, full_exp());
      else n_pass++;
   endtask

   task automatic test_err();
      drive_write(5, 4'hF, 1'b0);
      n_total++;
      if (wr_err !== 1'b0) $display("FAIL err_idx5: got %b want 0", wr_err);
      else n_pass++;
      drive_write(7, 4'h3, 1'b0);
      n_total++;
      if (wr_err !== 1'b1) $display("FAIL err_set: got %b want 1", wr_err);
      else n_pass++;
      n_total++;
      if (wr_if.wr_ready !== (cyc % SLOT < SD))
         $display("FAIL err_ready: got %b want %b", wr_if.wr_ready, (cyc % SLOT < SD));
      else n_pass++;
      repeat (FRAME + SLOT) @(negedge clk);
      n_total++;
      if (wr_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", wr_err);
      else n_pass++;
      n_total++;
      if (hex_out !== full_exp()) $display("FAIL err_hex: got %h want %h", hex_out, full_exp());
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      for (int d = 0; d < ND; d++) drive_write(d, 4'(d + 1), 1'b0);
      repeat (FRAME + SLOT) @(negedge clk);
      n_total++;
      if (hex_out !== full_exp()) $display("FAIL fill_all: got %h want %h", hex_out, full_exp());
      else n_pass++;
      for (int i = 0; i < SLOT && (cyc % SLOT) != SLOT - 1; i++) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if (hex_out !== {ND{7'h7F}}) $display("FAIL midrst_dark: got %h want all 7F", hex_out);
      else n_pass++;
      clear_model();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (FRAME + SLOT) @(negedge clk);
      n_total++;
      if (hex_out !== {ND{7'h7F}}) $display("FAIL postrst_dark: got %h want all 7F", hex_out);
      else n_pass++;
      n_total++;
      if (wr_err !== 1'b0) $display("FAIL postrst_err: got %b want 0", wr_err);
      else n_pass++;
   endtask

`ifdef HEX_SCAN_BLINK_EN
   task automatic test_blink();
      blink_mask = 6'b000001;
      m_mask     = 6'b000001;
      drive_write(0, 4'h8, 1'b0);
      for (int i = 0; i < 6 * FRAME; i++) begin
         @(negedge clk);
         if (cyc % FRAME == SLOT && cyc >= FRAME) begin
            n_total++;
            if (hex_out[6:0] !== (((((cyc - 1) / FRAME) / BF) % 2 == 1) ? 7'h7F : 7'h00))
               $display("FAIL blink_d0: got %h (cyc %0d)", hex_out[6:0], cyc);
            else n_pass++;
         end
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_write();
      test_hold();
      test_err();
      test_reset_mid();
`ifdef HEX_SCAN_BLINK_EN
      test_blink();
`endif
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
